// File: rtl/rv32i_soc_top.sv
// rv32i_soc_top: single-cycle RV32I core with instruction ROM, data RAM and 32x32 register file.
// Optional macro ECALL_HALT_EN: ECALL/EBREAK freeze the PC and suppress all writes until reset.
module rv32i_soc_top #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "imem.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf_q [32];
  logic [31:0] pc_q, pc_d;

  // Trace nets observed hierarchically; names are fixed.
  logic [31:0] addr, o_data, i_data;
  logic        ld, st;

  logic [31:0] instr_s, imm_s, rs1_s, rs2_s, op_b_s, alu_s, load_s, wb_s, pc4_s;
  logic [15:0] half_s;
  logic [7:0]  lane_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [2:0]  f3_s;
  logic [3:0]  be_s;
  logic        take_s, wr_s, we_s, halt_s;

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = 32'h0000_0000;
  end

  // Fetch, field split, register read and immediate generation.
  always_comb begin
    instr_s  = imem[pc_q[IAW+1:2]];
    opcode_s = instr_s[6:0];
    rd_s     = instr_s[11:7];
    f3_s     = instr_s[14:12];
    rs1_s    = (instr_s[19:15] == 5'd0) ? 32'h0000_0000 : rf_q[instr_s[19:15]];
    rs2_s    = (instr_s[24:20] == 5'd0) ? 32'h0000_0000 : rf_q[instr_s[24:20]];
    case (opcode_s)
      OP_LUI, OP_AUIPC: imm_s = {instr_s[31:12], 12'h000};
      OP_JAL:    imm_s = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
      OP_BRANCH: imm_s = {{20{instr_s[31]}}, instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
      OP_STORE:  imm_s = {{21{instr_s[31]}}, instr_s[30:25], instr_s[11:7]};
      default:   imm_s = {{21{instr_s[31]}}, instr_s[30:20]};
    endcase
  end

  // ALU: full f3 decode only for OP/OP-IMM, plain add (address/target) otherwise.
  always_comb begin
    op_b_s = (opcode_s == OP_REG) ? rs2_s : imm_s;
    alu_s  = rs1_s + op_b_s;
    if (opcode_s == OP_IMM || opcode_s == OP_REG) begin
      case (f3_s)
        3'b000: begin
          if (opcode_s == OP_REG && instr_s[30]) alu_s = rs1_s - op_b_s;
          else alu_s = rs1_s + op_b_s;
        end
        3'b001: alu_s = rs1_s << op_b_s[4:0];
        3'b010: alu_s = {31'h0000_0000, ($signed(rs1_s) < $signed(op_b_s))};
        3'b011: alu_s = {31'h0000_0000, (rs1_s < op_b_s)};
        3'b100: alu_s = rs1_s ^ op_b_s;
        3'b101: begin
          if (instr_s[30]) alu_s = $unsigned($signed(rs1_s) >>> op_b_s[4:0]);
          else alu_s = rs1_s >> op_b_s[4:0];
        end
        3'b110: alu_s = rs1_s | op_b_s;
        3'b111: alu_s = rs1_s & op_b_s;
        default: alu_s = rs1_s + op_b_s;
      endcase
    end else begin
      alu_s = rs1_s + op_b_s;
    end
  end

  assign addr = alu_s;

`ifdef ECALL_HALT_EN
  assign halt_s = (opcode_s == OP_SYSTEM);
`else
  assign halt_s = 1'b0;
`endif

  // Branch comparator.
  always_comb begin
    case (f3_s)
      3'b000:  take_s = (rs1_s == rs2_s);
      3'b001:  take_s = (rs1_s != rs2_s);
      3'b100:  take_s = ($signed(rs1_s) < $signed(rs2_s));
      3'b101:  take_s = ($signed(rs1_s) >= $signed(rs2_s));
      3'b110:  take_s = (rs1_s < rs2_s);
      3'b111:  take_s = (rs1_s >= rs2_s);
      default: take_s = 1'b0;
    endcase
  end

  // Data memory lanes: store replication/enables and load extraction share addr[1:0] rules.
  always_comb begin
    ld     = (opcode_s == OP_LOAD);
    st     = rst & (opcode_s == OP_STORE) & ~halt_s;
    o_data = dmem[addr[DAW+1:2]];
    case (f3_s[1:0])
      2'b00: begin
        i_data = {4{rs2_s[7:0]}};
        be_s   = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        i_data = {2{rs2_s[15:0]}};
        be_s   = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        i_data = rs2_s;
        be_s   = 4'b1111;
      end
    endcase
    lane_s = o_data[{addr[1:0], 3'b000} +: 8];
    half_s = addr[1] ? o_data[31:16] : o_data[15:0];
    case (f3_s)
      3'b000:  load_s = {{24{lane_s[7]}}, lane_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b100:  load_s = {24'h00_0000, lane_s};
      3'b101:  load_s = {16'h0000, half_s};
      default: load_s = o_data;
    endcase
  end

  // Writeback select and next-PC.
  always_comb begin
    pc4_s = pc_q + 32'd4;
    case (opcode_s)
      OP_LUI:          begin wb_s = imm_s;         wr_s = 1'b1; end
      OP_AUIPC:        begin wb_s = pc_q + imm_s;  wr_s = 1'b1; end
      OP_JAL, OP_JALR: begin wb_s = pc4_s;         wr_s = 1'b1; end
      OP_LOAD:         begin wb_s = load_s;        wr_s = 1'b1; end
      OP_IMM, OP_REG:  begin wb_s = alu_s;         wr_s = 1'b1; end
      default:         begin wb_s = alu_s;         wr_s = 1'b0; end
    endcase
    we_s = wr_s & (rd_s != 5'd0) & ~halt_s;
    if (halt_s) begin
      pc_d = pc_q;
    end else if (opcode_s == OP_JAL || (opcode_s == OP_BRANCH && take_s)) begin
      pc_d = pc_q + imm_s;
    end else if (opcode_s == OP_JALR) begin
      pc_d = addr & ~32'h0000_0001;
    end else begin
      pc_d = pc4_s;
    end
  end

  // Architectural state: PC and register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
      if (we_s) rf_q[rd_s] <= wb_s;
    end
  end

  // DMEM has no reset so its contents survive rst; st is already low in reset.
  always_ff @(posedge clk) begin
    if (st) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) dmem[addr[DAW+1:2]][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_rv32i_soc_top.sv
// Directed-program bench for rv32i_soc_top; programs are assembled here and poked into the ROM.
module tb_rv32i_soc_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prog [$];

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LDO = 7'b0000011;

  rv32i_soc_top #(.IMEM_INIT("")) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
  endtask

  // Leaves the bench at a falling edge with rst just released and imem[0] current.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    prog = '{enc_s(12'd64, 5'd1, 5'd0, 3'd2), enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI), enc_j(21'h1FFFFC, 5'd0)};
    #1 rst = 1'b0;
    load_prog();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (dut.pc_q !== 32'h0 || dut.st !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: pc=%h st=%b required pc=00000000 st=0", dut.pc_q, dut.st);
      end
    end
    for (int r = 1; r < 32; r++) begin
      checks++;
      if (dut.rf_q[r] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rf x%0d: got %h required 00000000", r, dut.rf_q[r]);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dut.st !== 1'b1 || dut.addr !== 32'd64) begin
      errors++;
      $display("FAIL first_fetch: st=%b addr=%h required st=1 addr=00000040", dut.st, dut.addr);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (dut.rf_q[1] !== 32'd5) begin
      errors++;
      $display("FAIL run_x1: got %h required 00000005", dut.rf_q[1]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dut.pc_q !== 32'h0 || dut.rf_q[1] !== 32'h0 || dut.st !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pc=%h x1=%h st=%b required 0/0/0", dut.pc_q, dut.rf_q[1], dut.st);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [7];
    prog = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OPI),
             enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4),
             enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd6)};
    exp_v = '{32'h0, 32'h5, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFF8, 32'h1, 32'h0};
    load_prog();
    do_reset();
    repeat (6) @(negedge clk);
    for (int r = 1; r < 7; r++) begin
      checks++;
      if (dut.rf_q[r] !== exp_v[r]) begin
        errors++;
        $display("FAIL alu x%0d: got %h required %h", r, dut.rf_q[r], exp_v[r]);
      end
    end
  endtask

  task automatic test_shift_logic();
    logic [31:0] exp_v [16];
    prog = '{enc_i(12'hFF0, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'h402, 5'd1, 3'd5, 5'd2, OPI),
             enc_i(12'h01C, 5'd1, 3'd5, 5'd3, OPI), enc_i(12'h004, 5'd1, 3'd1, 5'd4, OPI),
             enc_i(12'h0FF, 5'd1, 3'd4, 5'd5, OPI), enc_i(12'h7F0, 5'd1, 3'd7, 5'd6, OPI),
             enc_i(12'h123, 5'd0, 3'd6, 5'd7, OPI), enc_i(12'h021, 5'd0, 3'd0, 5'd8, OPI),
             enc_r(7'h00, 5'd8, 5'd7, 3'd1, 5'd9), enc_r(7'h20, 5'd8, 5'd1, 3'd5, 5'd10),
             enc_i(12'hFF1, 5'd1, 3'd2, 5'd11, OPI), enc_i(12'h005, 5'd1, 3'd3, 5'd12, OPI),
             enc_r(7'h00, 5'd8, 5'd1, 3'd5, 5'd13), enc_r(7'h00, 5'd1, 5'd7, 3'd4, 5'd14),
             enc_r(7'h00, 5'd8, 5'd7, 3'd7, 5'd15)};
    exp_v = '{32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'h0000_000F, 32'hFFFF_FF00, 32'hFFFF_FF0F,
              32'h0000_07F0, 32'h0000_0123, 32'h0000_0021, 32'h0000_0246, 32'hFFFF_FFF8,
              32'h1, 32'h0, 32'h7FFF_FFF8, 32'hFFFF_FED3, 32'h0000_0021};
    load_prog();
    do_reset();
    repeat (15) @(negedge clk);
    for (int r = 1; r < 16; r++) begin
      checks++;
      if (dut.rf_q[r] !== exp_v[r]) begin
        errors++;
        $display("FAIL shift_logic x%0d: got %h required %h", r, dut.rf_q[r], exp_v[r]);
      end
    end
  endtask

  task automatic test_load_store();
    logic [31:0] exp_v [11];
    prog = '{enc_u(20'h12345, 5'd1, 7'b0110111), enc_i(12'h678, 5'd1, 3'd0, 5'd1, OPI),
             enc_s(12'd8, 5'd1, 5'd0, 3'd2), enc_i(12'd9, 5'd0, 3'd0, 5'd2, LDO),
             enc_i(12'd10, 5'd0, 3'd5, 5'd3, LDO), enc_i(12'hF80, 5'd0, 3'd0, 5'd5, OPI),
             enc_s(12'd12, 5'd5, 5'd0, 3'd0), enc_i(12'd12, 5'd0, 3'd0, 5'd6, LDO),
             enc_i(12'd12, 5'd0, 3'd4, 5'd7, LDO), enc_s(12'd18, 5'd5, 5'd0, 3'd1),
             enc_i(12'd18, 5'd0, 3'd1, 5'd8, LDO), enc_i(12'd19, 5'd0, 3'd5, 5'd9, LDO),
             enc_i(12'd11, 5'd0, 3'd2, 5'd10, LDO)};
    exp_v = '{32'h0, 32'h1234_5678, 32'h0000_0056, 32'h0000_1234, 32'h0, 32'hFFFF_FF80,
              32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_FF80, 32'h1234_5678};
    load_prog();
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut.addr !== 32'd8 || dut.st !== 1'b1 || dut.i_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sw_nets: addr=%h st=%b i_data=%h required 00000008/1/12345678", dut.addr, dut.st, dut.i_data);
    end
    @(negedge clk);
    checks++;
    if (dut.ld !== 1'b1 || dut.o_data !== 32'h1234_5678 || dut.st !== 1'b0) begin
      errors++;
      $display("FAIL lb_nets: ld=%b o_data=%h st=%b required 1/12345678/0", dut.ld, dut.o_data, dut.st);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dut.i_data !== 32'h8080_8080) begin
      errors++;
      $display("FAIL sb_repl: got %h required 80808080", dut.i_data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dut.i_data !== 32'hFF80_FF80) begin
      errors++;
      $display("FAIL sh_repl: got %h required ff80ff80", dut.i_data);
    end
    repeat (4) @(negedge clk);
    for (int r = 1; r < 11; r++) begin
      checks++;
      if (dut.rf_q[r] !== exp_v[r]) begin
        errors++;
        $display("FAIL load x%0d: got %h required %h", r, dut.rf_q[r], exp_v[r]);
      end
    end
    checks++;
    if (dut.dmem[2] !== 32'h1234_5678 || dut.dmem[3] !== 32'h0000_0080 || dut.dmem[4] !== 32'hFF80_0000) begin
      errors++;
      $display("FAIL dmem_words: got %h %h %h required 12345678 00000080 ff800000",
               dut.dmem[2], dut.dmem[3], dut.dmem[4]);
    end
  endtask

  task automatic test_sb_lane();
    prog = '{enc_i(12'h0AB, 5'd0, 3'd0, 5'd7, OPI), enc_s(12'd5, 5'd7, 5'd0, 3'd0)};
    load_prog();
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut.dmem[1] !== 32'h0000_AB00 || dut.dmem[0] !== 32'h0) begin
      errors++;
      $display("FAIL sb_lane: dmem1=%h dmem0=%h required 0000ab00 00000000", dut.dmem[1], dut.dmem[0]);
    end
  endtask

  task automatic test_branch_jump();
    logic [31:0] trace [9];
    logic [31:0] exp_v [6];
    prog = '{enc_i(12'd1, 5'd0, 3'd0, 5'd2, OPI), enc_b(13'd8, 5'd0, 5'd0, 3'd0),
             enc_i(12'd99, 5'd0, 3'd0, 5'd2, OPI), enc_b(13'd8, 5'd0, 5'd0, 3'd1),
             enc_i(12'd7, 5'd0, 3'd0, 5'd3, OPI), enc_j(21'd12, 5'd1),
             enc_i(12'd55, 5'd0, 3'd0, 5'd4, OPI), enc_j(21'd0, 5'd0),
             enc_i(12'd9, 5'd0, 3'd0, 5'd5, OPI), enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'b1100111)};
    trace = '{32'd4, 32'd12, 32'd16, 32'd20, 32'd32, 32'd36, 32'd24, 32'd28, 32'd28};
    exp_v = '{32'd0, 32'd24, 32'd1, 32'd7, 32'd55, 32'd9};
    load_prog();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (dut.pc_q !== trace[c]) begin
        errors++;
        $display("FAIL pc_trace step %0d: got %h required %h", c, dut.pc_q, trace[c]);
      end
    end
    for (int r = 1; r < 6; r++) begin
      checks++;
      if (dut.rf_q[r] !== exp_v[r]) begin
        errors++;
        $display("FAIL branch x%0d: got %h required %h", r, dut.rf_q[r], exp_v[r]);
      end
    end
  endtask

  task automatic test_branch_cmp();
    logic [31:0] exp_v [5];
    prog = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd1, 5'd0, 3'd0, 5'd2, OPI),
             enc_b(13'd8, 5'd2, 5'd1, 3'd4), enc_i(12'd1, 5'd0, 3'd0, 5'd10, OPI),
             enc_b(13'd8, 5'd2, 5'd1, 3'd6), enc_i(12'd2, 5'd0, 3'd0, 5'd11, OPI),
             enc_b(13'd8, 5'd1, 5'd2, 3'd5), enc_i(12'd3, 5'd0, 3'd0, 5'd12, OPI),
             enc_b(13'd8, 5'd2, 5'd1, 3'd7), enc_i(12'd4, 5'd0, 3'd0, 5'd13, OPI),
             enc_u(20'h00001, 5'd14, 7'b0010111), enc_j(21'd0, 5'd0)};
    exp_v = '{32'd0, 32'd2, 32'd0, 32'd0, 32'h0000_1028};
    load_prog();
    do_reset();
    repeat (12) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut.rf_q[10 + k] !== exp_v[k]) begin
        errors++;
        $display("FAIL branch_cmp x%0d: got %h required %h", 10 + k, dut.rf_q[10 + k], exp_v[k]);
      end
    end
    checks++;
    if (dut.pc_q !== 32'd44) begin
      errors++;
      $display("FAIL branch_cmp_pc: got %h required 0000002c", dut.pc_q);
    end
  endtask

  task automatic test_x0_ecall();
    prog = '{enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI), enc_i(12'd7, 5'd0, 3'd0, 5'd0, OPI),
             enc_r(7'h00, 5'd1, 5'd0, 3'd0, 5'd2), 32'h0000_0073,
             enc_i(12'd5, 5'd0, 3'd0, 5'd3, OPI), enc_j(21'd0, 5'd0)};
    load_prog();
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut.rf_q[2] !== 32'd1 || dut.rf_q[0] !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: x2=%h x0=%h required 00000001 00000000", dut.rf_q[2], dut.rf_q[0]);
    end
`ifdef ECALL_HALT_EN
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (dut.pc_q !== 32'd12) begin
        errors++;
        $display("FAIL ecall_halt cycle %0d: pc=%h required 0000000c", c, dut.pc_q);
      end
    end
    checks++;
    if (dut.rf_q[3] !== 32'd0) begin
      errors++;
      $display("FAIL ecall_halt_x3: got %h required 00000000", dut.rf_q[3]);
    end
`else
    @(negedge clk);
    checks++;
    if (dut.pc_q !== 32'd16) begin
      errors++;
      $display("FAIL ecall_nop_pc: got %h required 00000010", dut.pc_q);
    end
    @(negedge clk);
    checks++;
    if (dut.rf_q[3] !== 32'd5 || dut.pc_q !== 32'd20) begin
      errors++;
      $display("FAIL ecall_nop_next: x3=%h pc=%h required 00000005 00000014", dut.rf_q[3], dut.pc_q);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift_logic();
    test_load_store();
    test_sb_lane();
    test_branch_jump();
    test_branch_cmp();
    test_x0_ecall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
